// File: rtl/if_fetch_pkg.sv
// Shared constants and types for the IF stage: stall-bus encoding, bus widths
// and the ID-side hold buffer state type.
package if_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam int          STALL_W_DEFAULT  = 6;

    // Stall bus bit encoding: a set bit stops that pipeline register
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam int STALL_PC    = 0;   // PC register hold
    localparam int STALL_IF_ID = 1;   // IF/ID register hold
    localparam int STALL_ID    = 2;   // ID stage hold

    localparam int BR_WD       = 33;  // {br_e, br_addr[31:0]}
    localparam int IF_TO_ID_WD = 33;  // {ce, pc[31:0]}

    // Instruction hold buffer: PASS forwards SRAM data, HOLD replays a captured word
    typedef enum logic {
        HOLD_PASS = 1'b0,
        HOLD_HOLD = 1'b1
    } hold_st_e;

endpackage

// File: rtl/if_fetch_if.sv
// Bundle of every IF-stage signal except clock and reset.
// Flow control: there is no valid/ready pair; downstream stages throttle IF
// only through the stall bus, where a STOP bit freezes the corresponding
// pipeline register at the next rising edge, and if_to_id_bus[32] / id_inst_valid
// act as the valid qualifiers for the PC and instruction word respectively.
interface if_fetch_if #(
    parameter int STALL_W = 6
);
    import if_fetch_pkg::*;

    logic [STALL_W-1:0]     stall;
    logic [BR_WD-1:0]       br_bus;
    logic [IF_TO_ID_WD-1:0] if_to_id_bus;
    logic                   inst_sram_en;
    logic [3:0]             inst_sram_wen;
    logic [31:0]            inst_sram_addr;
    logic [31:0]            inst_sram_wdata;
    logic [31:0]            inst_sram_rdata;
    logic [31:0]            id_inst;
    logic                   id_inst_valid;
    hold_st_e               hold_st;        // debug view of the hold buffer FSM

    modport master (
        input  stall, br_bus, inst_sram_rdata,
        output if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr,
               inst_sram_wdata, id_inst, id_inst_valid, hold_st
    );

    modport slave (
        output stall, br_bus, inst_sram_rdata,
        input  if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr,
               inst_sram_wdata, id_inst, id_inst_valid, hold_st
    );

endinterface

// File: rtl/if_fetch_inst_hold_buf.sv
// ID-side instruction holder: tracks whether ID holds a real instruction and
// keeps the fetched word stable while ID is stalled, since the synchronous SRAM
// moves on to the next address as soon as the stall begins.
module if_fetch_inst_hold_buf
    import if_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if_id,
    input  logic        stall_id,
    input  logic        ce,
    input  logic [31:0] rdata,
    output logic [31:0] id_inst,
    output logic        id_inst_valid,
    output hold_st_e    hold_st
);

    hold_st_e    state_r;
    hold_st_e    state_n;
    logic        capture;
    logic [31:0] hold_buf;
    logic        id_v;

    // Next state: enter HOLD when both IF/ID and ID are frozen, leave as soon as either runs
    always_comb begin
        state_n = state_r;
        capture = 1'b0;
        case (state_r)
            HOLD_PASS: begin
                if (stall_if_id == STOP && stall_id == STOP) begin
                    state_n = HOLD_HOLD;
                    capture = 1'b1;
                end
            end
            HOLD_HOLD: begin
                if (stall_if_id == NO_STOP || stall_id == NO_STOP) begin
                    state_n = HOLD_PASS;
                end
            end
            default: state_n = HOLD_PASS;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= HOLD_PASS;
        end else begin
            state_r <= state_n;
        end
    end

    // Capture the word on HOLD entry only; later SRAM data is ignored until release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_buf <= 32'h0;
        end else if (capture) begin
            hold_buf <= rdata;
        end
    end

    // Valid follows the ID register load rule: bubble, load from IF, or hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_v <= 1'b0;
        end else if (stall_if_id == STOP && stall_id == NO_STOP) begin
            id_v <= 1'b0;
        end else if (stall_if_id == NO_STOP) begin
            id_v <= ce;
        end
    end

    // Output mux; a bubble presents all-zero, which decodes as a harmless sll $0
    always_comb begin
        id_inst = 32'h0;
        if (id_v) begin
            id_inst = (state_r == HOLD_HOLD) ? hold_buf : rdata;
        end
    end

    assign id_inst_valid = id_v;
    assign hold_st       = state_r;

endmodule

// File: rtl/if_fetch.sv
// IF stage: owns the PC, issues instruction SRAM reads, applies branch/jump
// redirects (remembering one that arrives while the PC is held) and hands the
// fetched word to ID through the hold buffer.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          STALL_W  = STALL_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    if_fetch_if.master bus
);

    logic [31:0] pc_r;
    logic        ce_r;
    logic        br_pend;
    logic [31:0] pend_addr;
    logic [31:0] next_pc;
    logic        br_e;
    logic [31:0] br_addr;
    logic        unused_stall;

    assign {br_e, br_addr} = bus.br_bus;

    // Only the low stall bits concern IF; the rest belong to later stages
    assign unused_stall = ^bus.stall;

    // Fresh redirect beats a remembered one, which beats sequential fetch
    always_comb begin
        next_pc = pc_r + 32'd4;
        if (br_e) begin
            next_pc = br_addr;
        end else if (br_pend) begin
            next_pc = pend_addr;
        end
    end

    // PC advance or hold; a redirect seen during a hold is parked until release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r      <= RESET_PC - 32'd4;
            ce_r      <= 1'b0;
            br_pend   <= 1'b0;
            pend_addr <= 32'h0;
        end else if (bus.stall[STALL_PC] == NO_STOP) begin
            pc_r    <= next_pc;
            ce_r    <= 1'b1;
            br_pend <= 1'b0;
        end else if (br_e) begin
            br_pend   <= 1'b1;
            pend_addr <= br_addr;
        end
    end

    // SRAM read port is driven purely from registers, so br_bus never reaches it combinationally
    assign bus.inst_sram_en    = ce_r;
    assign bus.inst_sram_wen   = 4'b0000;
    assign bus.inst_sram_addr  = pc_r;
    assign bus.inst_sram_wdata = 32'h0;
    assign bus.if_to_id_bus    = {ce_r, pc_r};

    if_fetch_inst_hold_buf u_hold_buf (
        .clk           (clk),
        .rst           (rst),
        .stall_if_id   (bus.stall[STALL_IF_ID]),
        .stall_id      (bus.stall[STALL_ID]),
        .ce            (ce_r),
        .rdata         (bus.inst_sram_rdata),
        .id_inst       (bus.id_inst),
        .id_inst_valid (bus.id_inst_valid),
        .hold_st       (bus.hold_st)
    );

endmodule

// File: tb/tb_if_fetch.sv
// Bench for the IF stage: directed stimulus, a small SRAM model, a behavioural
// pipeline model compared every cycle, and literal expectations for key points.
module tb_if_fetch;
    import if_fetch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic        ovr = 1'b0;
    logic [31:0] tog = 32'h0;

    int n_checks = 0;
    int n_errors = 0;

    if_fetch_if sif ();

    if_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    // Clock
    always #5 clk = ~clk;

    // Contents of the instruction memory
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Synchronous SRAM, one-cycle read latency; ovr substitutes a driven word
    always @(posedge clk) begin
        if (sif.inst_sram_en) begin
            sif.inst_sram_rdata <= ovr ? tog : mem_word(sif.inst_sram_addr);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: what PC is being fetched, and which word ID is holding
    logic [31:0] m_pc;
    logic        m_ce;
    logic        m_pend_v;
    logic [31:0] m_pend_a;
    logic        m_id_v;
    logic [31:0] m_id_word;
    logic [31:0] m_fetched;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc      = 32'hBFC0_0000 - 32'd4;
            m_ce      = 1'b0;
            m_pend_v  = 1'b0;
            m_pend_a  = 32'h0;
            m_id_v    = 1'b0;
            m_id_word = 32'h0;
        end else begin
            m_fetched = ovr ? tog : mem_word(m_pc);
            if (!sif.stall[1]) begin
                m_id_v    = m_ce;
                m_id_word = m_fetched;
            end else if (!sif.stall[2]) begin
                m_id_v = 1'b0;
            end
            if (!sif.stall[0]) begin
                if (sif.br_bus[32])  m_pc = sif.br_bus[31:0];
                else if (m_pend_v)   m_pc = m_pend_a;
                else                 m_pc = m_pc + 32'd4;
                m_ce     = 1'b1;
                m_pend_v = 1'b0;
            end else if (sif.br_bus[32]) begin
                m_pend_v = 1'b1;
                m_pend_a = sif.br_bus[31:0];
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        check("cmp_en",    {63'h0, sif.inst_sram_en}, {63'h0, m_ce});
        check("cmp_addr",  {32'h0, sif.inst_sram_addr}, {32'h0, m_pc});
        check("cmp_bus",   {31'h0, sif.if_to_id_bus}, {31'h0, m_ce, m_pc});
        check("cmp_wen",   {60'h0, sif.inst_sram_wen}, 64'h0);
        check("cmp_wdata", {32'h0, sif.inst_sram_wdata}, 64'h0);
        check("cmp_valid", {63'h0, sif.id_inst_valid}, {63'h0, m_id_v});
        check("cmp_inst",  {32'h0, sif.id_inst}, {32'h0, (m_id_v ? m_id_word : 32'h0)});
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] st, input logic bre, input logic [31:0] bra);
        sif.stall  = st;
        sif.br_bus = {bre, bra};
    endtask

    task automatic chk_addr(input string name, input logic [31:0] exp);
        check(name, {32'h0, sif.inst_sram_addr}, {32'h0, exp});
    endtask

    task automatic chk_inst(input string name, input logic [31:0] exp);
        check(name, {32'h0, sif.id_inst}, {32'h0, exp});
    endtask

    // Directed stimulus with literal expectations
    initial begin
        sif.inst_sram_rdata = 32'h0;
        drive(6'b0, 1'b0, 32'h0);
        #1 rst = 1'b1;
        tick();
        tick();
        check("rst_en",    {63'h0, sif.inst_sram_en}, 64'h0);
        check("rst_bus",   {31'h0, sif.if_to_id_bus}, {31'h0, 1'b0, 32'hBFBF_FFFC});
        check("rst_valid", {63'h0, sif.id_inst_valid}, 64'h0);
        chk_inst("rst_inst", 32'h0);
        rst = 1'b0;

        tick();
        chk_addr("first_fetch", 32'hBFC0_0000);
        check("first_valid", {63'h0, sif.id_inst_valid}, 64'h0);
        tick();
        chk_addr("seq_4", 32'hBFC0_0004);
        check("valid_rise", {63'h0, sif.id_inst_valid}, 64'h1);
        chk_inst("inst_0", 32'h0000_FFFF);
        tick();
        chk_addr("seq_8", 32'hBFC0_0008);
        chk_inst("inst_4", 32'h0004_FFFB);

        // Single-cycle branch with no stall
        drive(6'b0, 1'b1, 32'hBFC0_0100);
        tick();
        chk_addr("br_target", 32'hBFC0_0100);
        chk_inst("inst_8", 32'h0008_FFF7);
        drive(6'b0, 1'b0, 32'h0);
        tick();
        chk_addr("br_plus4", 32'hBFC0_0104);

        // Full stall while SRAM data toggles: ID must keep the word captured on entry
        ovr = 1'b1;
        tog = 32'h1111_1111;
        drive(6'b000111, 1'b0, 32'h0);
        tick();
        chk_addr("stall_pc_1", 32'hBFC0_0104);
        chk_inst("stall_inst_1", 32'h0100_FEFF);
        check("stall_hold_st", {63'h0, sif.hold_st}, {63'h0, HOLD_HOLD});
        tog = 32'h2222_2222;
        tick();
        chk_addr("stall_pc_2", 32'hBFC0_0104);
        chk_inst("stall_inst_2", 32'h0100_FEFF);
        tog = 32'h1111_1111;
        tick();
        chk_addr("stall_pc_3", 32'hBFC0_0104);
        chk_inst("stall_inst_3", 32'h0100_FEFF);
        tog = 32'h2222_2222;
        drive(6'b0, 1'b0, 32'h0);
        tick();
        chk_addr("release_pc", 32'hBFC0_0108);
        chk_inst("release_pass", 32'h2222_2222);
        check("release_st", {63'h0, sif.hold_st}, {63'h0, HOLD_PASS});
        ovr = 1'b0;
        tick();
        chk_addr("post_stall_pc", 32'hBFC0_010C);
        chk_inst("post_stall_inst", 32'h0108_FEF7);

        // Redirects during a PC hold: latest wins, taken at release
        drive(6'b000001, 1'b1, 32'hBFC0_0180);
        tick();
        chk_addr("pend_hold_1", 32'hBFC0_010C);
        drive(6'b000001, 1'b1, 32'hBFC0_0200);
        tick();
        chk_addr("pend_hold_2", 32'hBFC0_010C);
        drive(6'b0, 1'b0, 32'h0);
        tick();
        chk_addr("pend_taken", 32'hBFC0_0200);
        tick();
        chk_addr("pend_plus4", 32'hBFC0_0204);

        // Branch arriving with the release overrides the parked target
        drive(6'b000001, 1'b1, 32'hBFC0_0300);
        tick();
        drive(6'b0, 1'b1, 32'hBFC0_0400);
        tick();
        chk_addr("br_over_pend", 32'hBFC0_0400);
        drive(6'b0, 1'b0, 32'h0);
        tick();
        chk_addr("br_over_plus4", 32'hBFC0_0404);

        // Bubble into ID with PC held
        drive(6'b000011, 1'b0, 32'h0);
        tick();
        chk_addr("bubble_pc", 32'hBFC0_0404);
        check("bubble_valid", {63'h0, sif.id_inst_valid}, 64'h0);
        chk_inst("bubble_inst", 32'h0);
        drive(6'b0, 1'b0, 32'h0);
        tick();
        chk_addr("after_bubble_pc", 32'hBFC0_0408);
        chk_inst("after_bubble_inst", 32'h0404_FBFB);

        // Asynchronous reset mid-cycle with a redirect parked
        drive(6'b000001, 1'b1, 32'hBFC0_0500);
        tick();
        #2 rst = 1'b1;
        #1;
        check("async_en", {63'h0, sif.inst_sram_en}, 64'h0);
        check("async_valid", {63'h0, sif.id_inst_valid}, 64'h0);
        chk_inst("async_inst", 32'h0);
        check("async_bus", {31'h0, sif.if_to_id_bus}, {31'h0, 1'b0, 32'hBFBF_FFFC});
        drive(6'b0, 1'b0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_addr("restart_pc", 32'hBFC0_0000);
        check("restart_en", {63'h0, sif.inst_sram_en}, 64'h1);
        tick();
        chk_addr("restart_plus4", 32'hBFC0_0004);
        chk_inst("restart_inst", 32'h0000_FFFF);

        // PC wraps silently past the top of the address space
        drive(6'b0, 1'b1, 32'hFFFF_FFFC);
        tick();
        chk_addr("wrap_top", 32'hFFFF_FFFC);
        drive(6'b0, 1'b0, 32'h0);
        tick();
        chk_addr("wrap_zero", 32'h0000_0000);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
